// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_MAX_D_STREAK = 4;
  localparam int DEF_TIMEOUT      = 15;
endpackage

// File: rtl/mem_arb_timer.sv
// Loadable up-counter with clear/enable; o_tc flags the last count before TIMEOUT.
module mem_arb_timer #(
  parameter int TIMEOUT = 15,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr)  r_cnt <= '0;
    else if (i_load)     r_cnt <= i_load_val;
    else if (i_en)       r_cnt <= r_cnt + 1'b1;
  end

  // Terminal when this enabled cycle would bring the count up to TIMEOUT.
  assign o_tc = (r_cnt == TC_VAL);
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-fetch and D-access onto one single-port memory with D-streak
// anti-starvation, variable-latency handshake and timeout completion.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int           TW         = $clog2(TIMEOUT + 1);
  localparam logic [3:0]   STREAK_MAX = 4'(MAX_D_STREAK);

  state_t            r_state;
  logic              r_own;
  logic              r_we;
  logic [3:0]        r_streak;
  logic              r_i_ready, r_i_err, r_d_ready, r_d_err;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_starve, w_d_grant, w_i_grant, w_tmr_en, w_tmr_tc;

  // I wins only when it is waiting and D has used up its streak.
  assign w_starve  = i_req && (r_streak == STREAK_MAX);
  assign w_d_grant = (r_state == IDLE) && d_req && !w_starve;
  assign w_i_grant = (r_state == IDLE) && !w_d_grant && i_req;
  assign w_tmr_en  = (r_state == BUSY) && !mem_ack;

  mem_arb_timer #(.TIMEOUT(TIMEOUT), .W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_d_grant || w_i_grant),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_tmr_en),
    .o_tc       (w_tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_own       <= OWN_I;
      r_we        <= 1'b0;
      r_streak    <= '0;
      r_i_ready   <= 1'b0;
      r_i_err     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_ready   <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_grant) begin
            r_state     <= BUSY;
            r_own       <= OWN_D;
            r_we        <= d_we;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            if (i_req) r_streak <= (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 4'd1;
            else       r_streak <= '0;
          end else if (w_i_grant) begin
            r_state     <= BUSY;
            r_own       <= OWN_I;
            r_we        <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
            r_streak    <= '0;
          end
        end
        BUSY: begin
          if (mem_ack || w_tmr_tc) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            if (r_own == OWN_I) begin
              r_i_ready <= 1'b1;
              r_i_err   <= !mem_ack;
              r_i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              r_d_ready <= 1'b1;
              r_d_err   <= !mem_ack;
              // A completed store keeps the last load data.
              if (!mem_ack)   r_d_rdata <= '0;
              else if (!r_we) r_d_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_i_ready <= 1'b0;
          r_i_err   <= 1'b0;
          r_d_ready <= 1'b0;
          r_d_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_ready   = r_i_ready;
  assign i_err     = r_i_err;
  assign i_rdata   = r_i_rdata;
  assign d_ready   = r_d_ready;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ready, i_err, d_ready, d_err, mem_req, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: one outstanding access, its age in memory cycles, and a
  // one-cycle completion window during which nothing new is accepted.
  bit          m_live, m_cool, m_own_d, m_we;
  int          m_age, m_streak;
  logic          e_i_ready, e_i_err, e_d_ready, e_d_err, e_mem_req, e_mem_we;
  logic [DW-1:0] e_i_rdata, e_d_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic finish_access(input bit err, input logic [DW-1:0] data);
    m_live    = 0;
    m_cool    = 1;
    e_mem_req = 0;
    if (!m_own_d) begin
      e_i_ready = 1; e_i_err = err; e_i_rdata = err ? '0 : data;
    end else begin
      e_d_ready = 1; e_d_err = err;
      if (err)       e_d_rdata = '0;
      else if (!m_we) e_d_rdata = data;
    end
  endtask

  task automatic start_access(input bit own_d, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd);
    m_live = 1; m_age = 0; m_own_d = own_d; m_we = we;
    e_mem_req = 1; e_mem_we = we; e_mem_addr = a; e_mem_wdata = wd;
  endtask

  task automatic model_next();
    bit starve;
    if (reset) begin
      m_live = 0; m_cool = 0; m_streak = 0;
      e_i_ready = 0; e_i_err = 0; e_d_ready = 0; e_d_err = 0;
      e_i_rdata = '0; e_d_rdata = '0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
    end else if (m_cool) begin
      m_cool = 0;
      e_i_ready = 0; e_i_err = 0; e_d_ready = 0; e_d_err = 0;
    end else if (m_live) begin
      if (mem_ack) finish_access(0, mem_rdata);
      else begin
        m_age++;
        if (m_age == TO) finish_access(1, '0);
      end
    end else begin
      starve = i_req && (m_streak == MAXS);
      if (d_req && !starve) begin
        m_streak = i_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        start_access(1, d_we, d_addr, d_we ? d_wdata : d_wdata);
      end else if (i_req) begin
        m_streak = 0;
        start_access(0, 0, i_addr, '0);
      end
    end
  endtask

  task automatic compare();
    chk("i_ready",   i_ready,   e_i_ready);
    chk("i_err",     i_err,     e_i_err);
    chk("i_rdata",   i_rdata,   e_i_rdata);
    chk("d_ready",   d_ready,   e_d_ready);
    chk("d_err",     d_err,     e_d_err);
    chk("d_rdata",   d_rdata,   e_d_rdata);
    chk("mem_req",   mem_req,   e_mem_req);
    chk("mem_we",    mem_we,    e_mem_we);
    chk("mem_addr",  mem_addr,  e_mem_addr);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("one_ready", i_ready && d_ready, 1'b0);
  endtask

  // Inputs stay stable around the edge; outputs are compared on the falling edge.
  task automatic tick();
    model_next();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic drive_random(input int p);
    reset = ($urandom % 300 == 0);
    if (!i_req) begin
      if ($urandom % 4 == 0) begin i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
    end else if (i_ready) begin
      if ($urandom % 2 == 0) i_req = 0;
      else i_addr = $urandom & 32'hFFFF_FFFC;
    end else if ($urandom % 64 == 0) i_req = 0;
    if (!d_req) begin
      if ($urandom % 3 == 0) begin
        d_req = 1; d_we = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end
    end else if (d_ready) begin
      if ($urandom % 2 == 0) d_req = 0;
      else begin d_we = $urandom % 2; d_addr = $urandom; d_wdata = $urandom; end
    end else if ($urandom % 64 == 0) d_req = 0;
    if (mem_req) mem_ack = ($urandom % 100) < p;
    else         mem_ack = ($urandom % 10 == 0);
    mem_rdata = $urandom;
  endtask

  initial begin
    int seq[$];
    int n, r1, r2, g4, p;
    bit prev;

    reset = 1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ready", {i_ready, d_ready, i_err, d_err}, 4'b0);
    reset = 0;

    // Single fetch, zero-wait memory
    i_req = 1; i_addr = 32'h4;
    tick();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_addr", mem_addr, 32'h4);
    mem_ack = 1; mem_rdata = 32'h2009_0003;
    tick();
    chk("t1_i_ready", i_ready, 1'b1);
    chk("t1_i_rdata", i_rdata, 32'h2009_0003);
    chk("t1_i_err", i_err, 1'b0);
    i_req = 0; mem_ack = 0;
    tick(); tick();

    // Contention: store wins, fetch follows right after DONE
    i_req = 1; i_addr = 32'h10;
    d_req = 1; d_we = 1; d_addr = 32'h4; d_wdata = 32'hA;
    tick();
    chk("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_wdata", mem_wdata, 32'hA);
    chk("t2_mem_addr", mem_addr, 32'h4);
    tick();
    mem_ack = 1;
    tick();
    chk("t2_d_ready", d_ready, 1'b1);
    mem_ack = 0; d_req = 0;
    tick();
    chk("t2_gap", mem_req, 1'b0);
    tick();
    chk("t2_i_grant", {mem_req, mem_we}, 2'b10);
    chk("t2_i_addr", mem_addr, 32'h10);
    mem_ack = 1;
    tick();
    chk("t2_i_ready", i_ready, 1'b1);
    mem_ack = 0; i_req = 0;
    tick(); tick();

    // Starvation bound
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
    prev = 0;
    for (int k = 0; k < 40; k++) begin
      mem_ack = mem_req; mem_rdata = k;
      tick();
      if (mem_req && !prev) seq.push_back((mem_addr == 32'h100) ? 0 : 1);
      prev = mem_req;
    end
    n = 0;
    while (n < seq.size() && seq[n] == 1) n++;
    chk("t3_d_streak", n, 4);
    chk("t3_then_i", (seq.size() > 5) ? seq[4] : -1, 0);
    chk("t3_restart", (seq.size() > 5) ? seq[5] : -1, 1);
    i_req = 0; d_req = 0;
    for (int k = 0; k < 4; k++) begin mem_ack = mem_req; tick(); end
    mem_ack = 0;

    // Timeout on a load
    d_req = 1; d_we = 0; d_addr = 32'h40;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_req) n++;
      if (d_ready) break;
    end
    chk("t4_req_cycles", n, TO);
    chk("t4_d_ready", d_ready, 1'b1);
    chk("t4_d_err", d_err, 1'b1);
    chk("t4_d_rdata", d_rdata, 32'h0);
    d_req = 0;
    tick(); tick();
    mem_ack = 1;
    tick();
    chk("t4_late_ack", {mem_req, d_ready, d_err}, 3'b0);
    mem_ack = 0;
    tick();

    // Reset in the middle of an access
    i_req = 1; i_addr = 32'h80;
    tick(); tick();
    chk("t5_busy", mem_req, 1'b1);
    reset = 1;
    tick();
    chk("t5_rst", {mem_req, i_ready, d_ready}, 3'b0);
    reset = 0;
    tick();
    chk("t5_regrant", mem_req, 1'b1);
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    chk("t5_ready", i_ready, 1'b1);
    chk("t5_rdata", i_rdata, 32'hCAFE_0001);
    mem_ack = 0; i_req = 0;
    tick(); tick();

    // Back-to-back loads
    d_req = 1; d_we = 0; d_addr = 32'h4;
    r1 = -1; r2 = -1; g4 = 0; prev = 0;
    for (int k = 0; k < 20; k++) begin
      mem_ack = mem_req;
      mem_rdata = (mem_addr == 32'h4) ? 32'h1111 : 32'h2222;
      tick();
      if (mem_req && !prev && mem_addr == 32'h4) g4++;
      prev = mem_req;
      if (d_ready) begin
        if (r1 < 0) begin
          r1 = cyc; chk("t6_data1", d_rdata, 32'h1111); d_addr = 32'h8;
        end else if (r2 < 0) begin
          r2 = cyc; chk("t6_data2", d_rdata, 32'h2222); d_req = 0;
        end
      end
    end
    chk("t6_spacing", r2 - r1, 3);
    chk("t6_one_grant", g4, 1);
    mem_ack = 0;

    // Randomized traffic with varying memory latency
    for (int blk = 0; blk < 6; blk++) begin
      case (blk)
        0: p = 100; 1: p = 60; 2: p = 30; 3: p = 10; 4: p = 3; default: p = 50;
      endcase
      for (int k = 0; k < 500; k++) begin
        drive_random(p);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
